// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one FP_Unit between two cores.
//
// Each core raises in_reqN with its operands and op, and waits (out_stallN)
// until its one-cycle out_validN pulse. A round-robin pointer picks the core
// when both ask in the same cycle. Exactly one operation is in flight at a
// time. ADD/SUB/MUL have a fixed latency. DIV follows the FP_Unit stall,
// waits SETTLE_CYC cycles after it drops, and gives up after DIV_TIMEOUT
// cycles with a quiet NaN.
//
// Ports:
//   in_Clk, in_Rst                 clock, synchronous active-high reset
//   in_reqN, in_rs1_N, in_rs2_N,   core N request, operands and op
//   in_opN                         (00 ADD, 01 SUB, 10 MUL, 11 DIV)
//   out_stallN, out_validN         core N stall and result-valid pulse
//   out_result, out_timeout        shared result, divide-timeout flag
//   out_fpu_rs1/rs2/op/start       FP_Unit command
//   in_fpu_data, in_fpu_stall      FP_Unit result and busy
module fpu_arbiter #(
  parameter int SETTLE_CYC  = 2,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic        in_Clk,
  input  logic        in_Rst,
  input  logic        in_req0,
  input  logic        in_req1,
  input  logic [31:0] in_rs1_0,
  input  logic [31:0] in_rs2_0,
  input  logic [31:0] in_rs1_1,
  input  logic [31:0] in_rs2_1,
  input  logic [1:0]  in_op0,
  input  logic [1:0]  in_op1,
  output logic        out_stall0,
  output logic        out_stall1,
  output logic        out_valid0,
  output logic        out_valid1,
  output logic [31:0] out_result,
  output logic        out_timeout,
  output logic [31:0] out_fpu_rs1,
  output logic [31:0] out_fpu_rs2,
  output logic [1:0]  out_fpu_op,
  output logic        out_fpu_start,
  input  logic [31:0] in_fpu_data,
  input  logic        in_fpu_stall
);

  localparam int CNT_MAX   = (DIV_TIMEOUT > SETTLE_CYC) ? DIV_TIMEOUT : SETTLE_CYC;
  localparam int CNT_W_RAW = $clog2(CNT_MAX + 1);
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

  localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(DIV_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [31:0]      QNAN        = 32'h7fc00000;
  localparam logic [1:0]       OP_DIV      = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DIV_WAIT,
    SETTLE,
    CAPTURE,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             prio;
  logic             owner;
  logic             timed_out;
  logic [CNT_W-1:0] cnt;
  logic             grant;
  logic             grant_core;
  logic             div_expire;

  // Next-state logic and grant selection.
  // In DIV_WAIT the first cycle (cnt == 0) ignores the stall input because
  // the FP_Unit only raises its stall one cycle after start. A stall drop
  // wins over a timeout when both happen in the last allowed cycle.
  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_core = 1'b0;
    div_expire = 1'b0;
    case (state)
      IDLE: begin
        if (in_req0 && in_req1) begin
          grant      = 1'b1;
          grant_core = prio;
        end else if (in_req0) begin
          grant      = 1'b1;
          grant_core = 1'b0;
        end else if (in_req1) begin
          grant      = 1'b1;
          grant_core = 1'b1;
        end
        if (grant) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = (out_fpu_op == OP_DIV) ? DIV_WAIT : CAPTURE;
      end
      DIV_WAIT: begin
        if ((cnt != '0) && !in_fpu_stall) begin
          state_nxt = (SETTLE_CYC == 0) ? CAPTURE : SETTLE;
        end else if (cnt == DIV_LAST) begin
          state_nxt  = DONE;
          div_expire = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter, latched command and result registers.
  // The counter restarts on every state change so it measures time spent
  // in the current DIV_WAIT or SETTLE visit.
  always_ff @(posedge in_Clk) begin
    if (in_Rst) begin
      state       <= IDLE;
      prio        <= 1'b0;
      owner       <= 1'b0;
      timed_out   <= 1'b0;
      cnt         <= '0;
      out_result  <= '0;
      out_fpu_rs1 <= '0;
      out_fpu_rs2 <= '0;
      out_fpu_op  <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if ((state == DIV_WAIT) || (state == SETTLE)) begin
        cnt <= cnt + 1'b1;
      end
      if (grant) begin
        owner       <= grant_core;
        prio        <= ~grant_core;
        timed_out   <= 1'b0;
        out_fpu_rs1 <= grant_core ? in_rs1_1 : in_rs1_0;
        out_fpu_rs2 <= grant_core ? in_rs2_1 : in_rs2_0;
        out_fpu_op  <= grant_core ? in_op1   : in_op0;
      end
      if (state == CAPTURE) begin
        out_result <= in_fpu_data;
      end
      if (div_expire) begin
        out_result <= QNAN;
        timed_out  <= 1'b1;
      end
    end
  end

  // Pulses are forced low while reset is held, even before the first
  // reset edge has cleared the state register.
  assign out_fpu_start = ~in_Rst & (state == ISSUE);
  assign out_valid0    = ~in_Rst & (state == DONE) & ~owner;
  assign out_valid1    = ~in_Rst & (state == DONE) &  owner;
  assign out_timeout   = ~in_Rst & (state == DONE) &  timed_out;
  assign out_stall0    = in_req0 & ~out_valid0;
  assign out_stall1    = in_req1 & ~out_valid1;

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: self-checking bench for fpu_arbiter.
//
// A behavioural FP_Unit answers from a table of hand-computed IEEE-754
// results. Stimulus pushes the expected response of every request into a
// queue; a monitor on the falling edge pops and compares whenever a
// valid pulse appears, and also checks the stall outputs every cycle.
module tb_fpu_arbiter;

  localparam int          SETTLE_CYC    = 2;
  localparam int          DIV_TIMEOUT   = 64;
  localparam int          DIV_STALL_LEN = 4;
  localparam logic [1:0]  OP_ADD        = 2'b00;
  localparam logic [1:0]  OP_SUB        = 2'b01;
  localparam logic [1:0]  OP_MUL        = 2'b10;
  localparam logic [1:0]  OP_DIV        = 2'b11;

  logic        in_Clk = 1'b0;
  logic        in_Rst = 1'b1;
  logic        in_req0 = 1'b0;
  logic        in_req1 = 1'b0;
  logic [31:0] in_rs1_0 = '0;
  logic [31:0] in_rs2_0 = '0;
  logic [31:0] in_rs1_1 = '0;
  logic [31:0] in_rs2_1 = '0;
  logic [1:0]  in_op0 = '0;
  logic [1:0]  in_op1 = '0;
  logic        out_stall0;
  logic        out_stall1;
  logic        out_valid0;
  logic        out_valid1;
  logic [31:0] out_result;
  logic        out_timeout;
  logic [31:0] out_fpu_rs1;
  logic [31:0] out_fpu_rs2;
  logic [1:0]  out_fpu_op;
  logic        out_fpu_start;
  logic [31:0] in_fpu_data = '0;
  logic        in_fpu_stall = 1'b0;

  fpu_arbiter #(
    .SETTLE_CYC  (SETTLE_CYC),
    .DIV_TIMEOUT (DIV_TIMEOUT)
  ) dut (
    .in_Clk        (in_Clk),
    .in_Rst        (in_Rst),
    .in_req0       (in_req0),
    .in_req1       (in_req1),
    .in_rs1_0      (in_rs1_0),
    .in_rs2_0      (in_rs2_0),
    .in_rs1_1      (in_rs1_1),
    .in_rs2_1      (in_rs2_1),
    .in_op0        (in_op0),
    .in_op1        (in_op1),
    .out_stall0    (out_stall0),
    .out_stall1    (out_stall1),
    .out_valid0    (out_valid0),
    .out_valid1    (out_valid1),
    .out_result    (out_result),
    .out_timeout   (out_timeout),
    .out_fpu_rs1   (out_fpu_rs1),
    .out_fpu_rs2   (out_fpu_rs2),
    .out_fpu_op    (out_fpu_op),
    .out_fpu_start (out_fpu_start),
    .in_fpu_data   (in_fpu_data),
    .in_fpu_stall  (in_fpu_stall)
  );

  always #5 in_Clk = ~in_Clk;

  typedef struct {
    int          core;
    logic [31:0] result;
    logic        timeout;
    int          latency;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   start_cyc = 0;
  int   start_cnt = 0;
  bit   div_hang  = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic push_exp(input int core, input logic [31:0] result,
                          input logic timeout, input int latency);
    exp_t e;
    e.core    = core;
    e.result  = result;
    e.timeout = timeout;
    e.latency = latency;
    exp_q.push_back(e);
  endtask

  // Hand-computed single-precision results for the operand pairs used.
  function automatic logic [31:0] fpu_lookup(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] r;
    case ({op, a, b})
      {OP_ADD, 32'h3f800000, 32'h3f800000}: r = 32'h40000000;
      {OP_MUL, 32'h40000000, 32'h40400000}: r = 32'h40c00000;
      {OP_SUB, 32'h40400000, 32'h3f800000}: r = 32'h40000000;
      {OP_DIV, 32'h40c00000, 32'h40000000}: r = 32'h40400000;
      {OP_ADD, 32'h40200000, 32'h3fc00000}: r = 32'h40800000;
      {OP_ADD, 32'h40000000, 32'h40000000}: r = 32'h40800000;
      {OP_ADD, 32'h3f800000, 32'h40000000}: r = 32'h40400000;
      {OP_ADD, 32'h40400000, 32'h3f800000}: r = 32'h40800000;
      {OP_DIV, 32'h3f800000, 32'h40000000}: r = 32'h3f000000;
      default:                              r = 32'hdeadbeef;
    endcase
    return r;
  endfunction

  // FP_Unit model: fixed ops answer the cycle after start; DIV keeps stall
  // low for one cycle, then high for DIV_STALL_LEN cycles (or forever when
  // div_hang is set), then drops it with the result.
  bit          div_active = 1'b0;
  bit          div_first  = 1'b0;
  int          div_left   = 0;
  logic [31:0] div_res    = '0;

  always @(negedge in_Clk) begin : fpu_model
    if (in_Rst) begin
      in_fpu_stall = 1'b0;
      div_active   = 1'b0;
    end else if (out_fpu_start) begin
      in_fpu_stall = 1'b0;
      if (out_fpu_op == OP_DIV) begin
        div_active  = 1'b1;
        div_first   = 1'b1;
        div_left    = DIV_STALL_LEN;
        div_res     = fpu_lookup(out_fpu_op, out_fpu_rs1, out_fpu_rs2);
        in_fpu_data = 32'hffffffff;
      end else begin
        div_active  = 1'b0;
        in_fpu_data = fpu_lookup(out_fpu_op, out_fpu_rs1, out_fpu_rs2);
      end
    end else if (div_active) begin
      if (div_first) begin
        div_first = 1'b0;
      end else if (div_hang || (div_left > 0)) begin
        in_fpu_stall = 1'b1;
        if (div_left > 0) div_left--;
      end else begin
        in_fpu_stall = 1'b0;
        in_fpu_data  = div_res;
        div_active   = 1'b0;
      end
    end
  end

  // Monitor: stall rule every cycle, scoreboard pop on every valid pulse,
  // start-to-valid latency and exactly one start per completed operation.
  always @(negedge in_Clk) begin : monitor
    exp_t e;
    int   core;
    cyc++;
    if (in_Rst) begin
      start_cnt = 0;
    end else if (out_fpu_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    checkOutput("stall0", 32'(out_stall0), 32'(in_req0 && !out_valid0));
    checkOutput("stall1", 32'(out_stall1), 32'(in_req1 && !out_valid1));
    if (out_valid0 || out_valid1) begin
      core = out_valid1 ? 1 : 0;
      checkOutput("single_valid", 32'(out_valid0 && out_valid1), 32'(0));
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_valid core=%0d actual=1 required=0", core);
      end else begin
        e = exp_q.pop_front();
        checkOutput("valid_core", 32'(core), 32'(e.core));
        checkOutput("result", out_result, e.result);
        checkOutput("timeout", 32'(out_timeout), 32'(e.timeout));
        checkOutput("start_to_valid", 32'(cyc - start_cyc), 32'(e.latency));
        checkOutput("start_count", 32'(start_cnt), 32'(1));
      end
      start_cnt = 0;
    end else begin
      checkOutput("timeout_quiet", 32'(out_timeout), 32'(0));
    end
  end

  task automatic tick();
    @(posedge in_Clk);
    #1;
  endtask

  task automatic drive_core(input int core, input logic req, input logic [1:0] op,
                            input logic [31:0] a, input logic [31:0] b);
    if (core == 0) begin
      in_req0 = req; in_op0 = op; in_rs1_0 = a; in_rs2_0 = b;
    end else begin
      in_req1 = req; in_op1 = op; in_rs1_1 = a; in_rs2_1 = b;
    end
  endtask

  // Raise a request, hold it until the core's valid pulse (bounded), then
  // drop it. With scramble set, the operands are corrupted right after the
  // grant cycle. exp_wait < 0 skips the request-to-valid check.
  task automatic applyStimulus(input int core, input logic [1:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input bit scramble, input int exp_wait);
    int waited;
    bit seen;
    waited = 0;
    seen   = 1'b0;
    tick();
    drive_core(core, 1'b1, op, a, b);
    while (!seen && (waited < 300)) begin
      tick();
      waited++;
      seen = (core == 0) ? out_valid0 : out_valid1;
      if (scramble && (waited == 1) && !seen) begin
        drive_core(core, 1'b1, ~op, ~a, ~b);
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL valid_wait core=%0d actual=none required=pulse", core);
    end else if (exp_wait >= 0) begin
      checkOutput("req_to_valid", 32'(waited), 32'(exp_wait));
    end
    drive_core(core, 1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : stimulus
    // Reset state
    repeat (3) tick();
    checkOutput("rst_result", out_result, 32'h0);
    checkOutput("rst_fpu_rs1", out_fpu_rs1, 32'h0);
    checkOutput("rst_fpu_op", 32'(out_fpu_op), 32'(0));
    checkOutput("rst_start", 32'(out_fpu_start), 32'(0));
    in_Rst = 1'b0;
    tick();

    // Lone ADD on core 0, operands scrambled after grant
    push_exp(0, 32'h40000000, 1'b0, 2);
    applyStimulus(0, OP_ADD, 32'h3f800000, 32'h3f800000, 1'b1, 3);
    repeat (2) tick();

    // Core 1 DIV: stall low 1 cycle, high 4, then 2 settle cycles
    push_exp(1, 32'h40400000, 1'b0, 10);
    applyStimulus(1, OP_DIV, 32'h40c00000, 32'h40000000, 1'b0, 11);
    repeat (2) tick();

    // Simultaneous requests, pointer favours core 0
    push_exp(0, 32'h40c00000, 1'b0, 2);
    push_exp(1, 32'h40000000, 1'b0, 2);
    fork
      applyStimulus(0, OP_MUL, 32'h40000000, 32'h40400000, 1'b0, 3);
      applyStimulus(1, OP_SUB, 32'h40400000, 32'h3f800000, 1'b0, 7);
    join
    repeat (2) tick();

    // Core 1 request withdrawn before it could be granted
    push_exp(0, 32'h40400000, 1'b0, 2);
    fork
      applyStimulus(0, OP_ADD, 32'h3f800000, 32'h40000000, 1'b0, 3);
      begin
        tick();
        tick();
        drive_core(1, 1'b1, OP_ADD, 32'h3f800000, 32'h3f800000);
        tick();
        drive_core(1, 1'b0, OP_ADD, 32'h0, 32'h0);
      end
    join
    repeat (4) tick();

    // DIV that never finishes: timeout after 64 wait cycles
    div_hang = 1'b1;
    push_exp(0, 32'h7fc00000, 1'b1, 65);
    applyStimulus(0, OP_DIV, 32'h3f800000, 32'h40000000, 1'b0, 66);
    div_hang = 1'b0;
    repeat (2) tick();

    // Reset in the middle of a divide abandons it
    drive_core(1, 1'b1, OP_DIV, 32'h40c00000, 32'h40000000);
    repeat (4) tick();
    in_Rst = 1'b1;
    tick();
    checkOutput("midrst_result", out_result, 32'h0);
    checkOutput("midrst_fpu_rs1", out_fpu_rs1, 32'h0);
    checkOutput("midrst_fpu_rs2", out_fpu_rs2, 32'h0);
    checkOutput("midrst_fpu_op", 32'(out_fpu_op), 32'(0));
    checkOutput("midrst_start", 32'(out_fpu_start), 32'(0));
    checkOutput("midrst_valid1", 32'(out_valid1), 32'(0));
    checkOutput("midrst_timeout", 32'(out_timeout), 32'(0));
    drive_core(1, 1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    in_Rst = 1'b0;
    push_exp(0, 32'h40800000, 1'b0, 2);
    applyStimulus(0, OP_ADD, 32'h40200000, 32'h3fc00000, 1'b0, 3);
    repeat (2) tick();

    // Both cores requesting back to back: grants alternate 0,1,0,1
    in_Rst = 1'b1;
    tick();
    in_Rst = 1'b0;
    push_exp(0, 32'h40000000, 1'b0, 2);
    push_exp(1, 32'h40400000, 1'b0, 2);
    push_exp(0, 32'h40800000, 1'b0, 2);
    push_exp(1, 32'h40800000, 1'b0, 2);
    fork
      begin
        applyStimulus(0, OP_ADD, 32'h3f800000, 32'h3f800000, 1'b0, 3);
        applyStimulus(0, OP_ADD, 32'h40000000, 32'h40000000, 1'b0, 7);
      end
      begin
        applyStimulus(1, OP_ADD, 32'h3f800000, 32'h40000000, 1'b0, 7);
        applyStimulus(1, OP_ADD, 32'h40400000, 32'h3f800000, 1'b0, 7);
      end
    join
    repeat (4) tick();

    checkOutput("pending_expectations", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 2: cycles waited after FP_Unit divide stall drops before sampling the result.
REQ-002 SHALL have parameter DIV_TIMEOUT, default 64: maximum cycles spent waiting on divide stall.
REQ-003 in_Clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 in_Rst  input  1  reset, synchronous and active-high.
REQ-005 in_req0 / in_req1  input  1  core 0/1 requests an FP operation; held high until that core's out_valid pulse.
REQ-006 in_rs1_0, in_rs2_0 / in_rs1_1, in_rs2_1  input  32  core 0/1 operands (IEEE-754 single precision).
REQ-007 in_op0 / in_op1  input  2  core 0/1 operation: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-008 out_stall0 / out_stall1  output  1  stall to core 0/1 pipeline.
REQ-009 out_valid0 / out_valid1  output  1  one-cycle result-valid pulse to core 0/1.
REQ-010 out_result  output  32  result, shared by both cores; qualified by out_valid0/1.
REQ-011 out_timeout  output  1  pulses together with out_valid0/1 when the divide timed out.
REQ-012 out_fpu_rs1, out_fpu_rs2  output  32  FP_Unit operands.
REQ-013 out_fpu_op  output  2  FP_Unit op.
REQ-014 out_fpu_start  output  1  FP_Unit start.
REQ-015 in_fpu_data  input  32  FP_Unit out_data.
REQ-016 in_fpu_stall  input  1  FP_Unit out_stall.

Function
REQ-017 SHALL implement states IDLE, ISSUE, DIV_WAIT, SETTLE, CAPTURE, DONE.
REQ-018 IDLE: when no request is pending, SHALL remain in IDLE.
REQ-019 IDLE: when exactly one request is pending, SHALL grant it.
REQ-020 IDLE: when both requests are pending, SHALL grant the core selected by priority pointer prio.
REQ-021 On grant, SHALL latch the granted core's operands, op and owner id, toggle prio to the other core, and go to ISSUE.
REQ-022 ISSUE: out_fpu_start SHALL be 1 for exactly this one cycle, with out_fpu_rs1/rs2/op driven from the latched values.
REQ-023 Latched operands SHALL remain on out_fpu_rs1/rs2/op until DONE.
REQ-024 ISSUE -> CAPTURE when op != 11; ISSUE -> DIV_WAIT when op == 11.
REQ-025 DIV_WAIT: SHALL ignore in_fpu_stall in its first cycle.
REQ-026 DIV_WAIT: SHALL go to SETTLE on the first later cycle in which in_fpu_stall is 0.
REQ-027 SETTLE: SHALL last SETTLE_CYC cycles, then go to CAPTURE; SETTLE_CYC=0 SHALL skip SETTLE and go directly to CAPTURE.
REQ-028 CAPTURE: SHALL register in_fpu_data into out_result and go to DONE.
REQ-029 DONE: SHALL pulse out_valid of the owner for 1 cycle, then go to IDLE.
REQ-030 Fixed-latency op (ADD/SUB/MUL) timing: request seen in IDLE at cycle 0, start at cycle 1, capture at cycle 2, out_valid at cycle 3.
REQ-031 DIV_WAIT timeout: a counter SHALL count cycles spent in DIV_WAIT.
REQ-032 On reaching DIV_TIMEOUT, SHALL go to DONE with out_result=32'h7fc00000 and out_timeout=1.
REQ-033 out_stallN SHALL equal in_reqN AND NOT out_validN (combinational), so a requester stalls until its own result pulse.
REQ-034 A request withdrawn before grant SHALL be ignored.
REQ-035 After grant, operands are latched, so the core may change its inputs; the operation still completes and out_valid still pulses.
REQ-036 out_fpu_start SHALL never assert outside ISSUE.
REQ-037 At most one operation SHALL be in flight.
REQ-038 A new grant SHALL occur no earlier than the IDLE cycle following DONE.
REQ-039 out_result SHALL hold its value between valid pulses.

Reset
REQ-040 While in_Rst=1 at a rising edge, SHALL clear state to IDLE, prio=0 and all counters to 0.
REQ-041 While in_Rst=1 at a rising edge, SHALL set out_result, out_fpu_rs1, out_fpu_rs2 and out_fpu_op to 0.
REQ-042 While in_Rst=1, out_valid0/1, out_timeout and out_fpu_start SHALL be 0.
REQ-043 Reset mid-operation SHALL abandon the operation, with no valid pulse for it.
REQ-044 out_stallN SHALL follow REQ-033 during and after reset.

Verification
REQ-045 Core0 ADD 3f800000+3f800000 alone -> exactly one start pulse; out_valid0 3 cycles after request; out_result=40000000; out_stall0 high until valid.
REQ-046 Same cycle: core0 MUL 40000000*40400000, core1 SUB 40400000-3f800000 -> core0 served first with 40c00000, then core1 with 40000000; out_stall1 high throughout.
REQ-047 Core1 DIV 40c00000/40000000 -> single start; waits for stall fall plus 2 cycles; out_result=40400000; out_timeout=0.
REQ-048 FPU model holds in_fpu_stall=1 permanently on a DIV -> after 64 DIV_WAIT cycles, out_valid pulses with out_result=7fc00000 and out_timeout=1.
REQ-049 in_Rst asserted during DIV_WAIT -> all outputs 0, no out_valid; a following core0 ADD 40200000+3fc00000 returns 40800000.
REQ-050 Both cores request continuously -> grants alternate 0,1,0,1; no core receives two consecutive grants while the other waits.
